// File: rtl/fft_mem_pkg.sv
// Shared types and helpers for the FFT bit-reversal SRAM controller.
package fft_mem_pkg;

  typedef enum logic [1:0] {
    StFill,
    StDrain,
    StFlush
  } ctrl_state_e;

  localparam int unsigned MinLatency   = 1;
  localparam int unsigned MaxAddrWidth = 32;

  // Reverse the low `width` bits of addr; bits above width come back as zero.
  function automatic logic [MaxAddrWidth-1:0] bitrev(input logic [MaxAddrWidth-1:0] addr,
                                                     input int unsigned width);
    logic [MaxAddrWidth-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxAddrWidth; i++) begin
      if (i < width) r[i] = addr[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_sram_ctrl_if.sv
// Stream-in, stream-out and SRAM initiator signals of the bit-reversal controller.
interface fft_bitrev_sram_ctrl_if #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 9
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [DataWidth-1:0] in_data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [DataWidth-1:0] out_data_o;
  logic                 out_last_o;
  logic                 sram_cs_o;
  logic                 sram_wen_o;
  logic [AddrWidth-1:0] sram_addr_o;
  logic [DataWidth-1:0] sram_wdata_o;
  logic [DataWidth-1:0] sram_rdata_i;
  logic                 busy_o;

  modport master (
    input  in_valid_i, in_data_i, out_ready_i, sram_rdata_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o,
    output sram_cs_o, sram_wen_o, sram_addr_o, sram_wdata_o, busy_o
  );

  modport slave (
    output in_valid_i, in_data_i, out_ready_i, sram_rdata_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o,
    input  sram_cs_o, sram_wen_o, sram_addr_o, sram_wdata_o, busy_o
  );
endinterface

// File: rtl/fft_bitrev_sram_ctrl_rd_return_fifo.sv
// Small circular FIFO catching SRAM read returns; head is visible combinationally.
module rd_return_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end
endmodule

// File: rtl/fft_bitrev_sram_ctrl.sv
// Frame buffer: writes a frame in natural order, reads it back bit-reversed.
// Define FFT_BITREV_EN for bit-reversed read order; otherwise reads are in natural order.
module fft_bitrev_sram_ctrl
  import fft_mem_pkg::*;
#(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 9,
  parameter int unsigned Latency   = 1
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  fft_bitrev_sram_ctrl_if.master bus_io
);
  localparam int unsigned Lat   = (Latency < MinLatency) ? MinLatency : Latency;
  localparam int unsigned Depth = Lat + 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam logic [AddrWidth-1:0] LastAddr = '1;

  ctrl_state_e          state_q;
  logic [AddrWidth-1:0] wr_cnt_q, rd_cnt_q, rd_addr;
  logic [Lat-1:0]       pipe_vld_q, pipe_last_q;
  logic [CntW-1:0]      fifo_count;
  logic [DataWidth:0]   fifo_head;
  logic [31:0]          credits;
  logic                 in_hs, pop, issue, rd_last;

`ifdef FFT_BITREV_EN
  logic [MaxAddrWidth-1:0] rev_full;
  assign rev_full = bitrev(MaxAddrWidth'(rd_cnt_q), AddrWidth);
  assign rd_addr  = rev_full[AddrWidth-1:0];
`else
  assign rd_addr = rd_cnt_q;
`endif

  assign in_hs   = (state_q == StFill) && bus_io.in_valid_i;
  assign pop     = (fifo_count != '0) && bus_io.out_ready_i;
  // An entry popping this cycle frees its slot, which keeps the issue rate at one per cycle.
  assign credits = 32'(fifo_count) + 32'($countones(pipe_vld_q)) - 32'(pop);
  assign issue   = (state_q == StDrain) && (credits < Depth);
  assign rd_last = (rd_cnt_q == LastAddr);

  assign bus_io.in_ready_o  = (state_q == StFill);
  assign bus_io.busy_o      = !((state_q == StFill) && (wr_cnt_q == '0));
  assign bus_io.out_valid_o = (fifo_count != '0);
  assign bus_io.out_last_o  = fifo_head[DataWidth];
  assign bus_io.out_data_o  = fifo_head[DataWidth-1:0];

  always_comb begin
    bus_io.sram_cs_o    = 1'b0;
    bus_io.sram_wen_o   = 1'b0;
    bus_io.sram_addr_o  = '0;
    bus_io.sram_wdata_o = '0;
    if (in_hs) begin
      bus_io.sram_cs_o    = 1'b1;
      bus_io.sram_wen_o   = 1'b1;
      bus_io.sram_addr_o  = wr_cnt_q;
      bus_io.sram_wdata_o = bus_io.in_data_i;
    end else if (issue) begin
      bus_io.sram_cs_o   = 1'b1;
      bus_io.sram_addr_o = rd_addr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StFill;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (in_hs) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q == LastAddr) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (issue) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (rd_last) state_q <= StFlush;
          end
        end
        StFlush: begin
          if (pop && fifo_head[DataWidth]) begin
            state_q  <= StFill;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  // Tags follow each read through the SRAM latency so the return lands in the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= issue && rd_last;
      for (int unsigned i = 1; i < Lat; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  rd_return_fifo #(
    .Width (DataWidth + 1),
    .Depth (Depth)
  ) u_rd_return_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (pipe_vld_q[Lat-1]),
    .wdata_i ({pipe_last_q[Lat-1], bus_io.sram_rdata_i}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count)
  );
endmodule

// File: tb/tb_fft_bitrev_sram_ctrl.sv
// Directed bench: two controllers (read latency 1 and 3, 8-sample frames) fed identical stimulus.
module tb_fft_bitrev_sram_ctrl;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 9;
  localparam int          N  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  fft_bitrev_sram_ctrl_if #(.AddrWidth(AW), .DataWidth(DW)) bus1 ();
  fft_bitrev_sram_ctrl_if #(.AddrWidth(AW), .DataWidth(DW)) bus3 ();

  assign bus1.in_valid_i  = in_valid;
  assign bus1.in_data_i   = in_data;
  assign bus1.out_ready_i = out_ready;
  assign bus3.in_valid_i  = in_valid;
  assign bus3.in_data_i   = in_data;
  assign bus3.out_ready_i = out_ready;

  fft_bitrev_sram_ctrl #(.AddrWidth(AW), .DataWidth(DW), .Latency(1)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus1)
  );

  fft_bitrev_sram_ctrl #(.AddrWidth(AW), .DataWidth(DW), .Latency(3)) dut3 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus3)
  );

  // SRAM models: read data appears Latency cycles after the request cycle.
  logic [DW-1:0] mem1 [N];
  logic [DW-1:0] mem3 [N];
  logic [DW-1:0] rp1;
  logic [DW-1:0] rp3 [3];

  always @(posedge clk) begin
    if (bus1.sram_cs_o && bus1.sram_wen_o) mem1[bus1.sram_addr_o] <= bus1.sram_wdata_o;
    if (bus1.sram_cs_o && !bus1.sram_wen_o) rp1 <= mem1[bus1.sram_addr_o];
    if (bus3.sram_cs_o && bus3.sram_wen_o) mem3[bus3.sram_addr_o] <= bus3.sram_wdata_o;
    rp3[0] <= (bus3.sram_cs_o && !bus3.sram_wen_o) ? mem3[bus3.sram_addr_o] : 'x;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign bus1.sram_rdata_i = rp1;
  assign bus3.sram_rdata_i = rp3[2];

  // Monitor: sole writer of the logs below; tests index from snapshots.
  logic [AW-1:0] wa1 [$];
  logic [DW-1:0] wd1 [$];
  logic [DW-1:0] od1 [$];
  logic [DW-1:0] od3 [$];
  logic          ol1 [$];
  logic          ol3 [$];
  int            rd1 = 0;
  int            rd3 = 0;
  int            bad_wr = 0;

  always @(negedge clk) begin
    if (bus1.sram_cs_o && bus1.sram_wen_o) begin
      wa1.push_back(bus1.sram_addr_o);
      wd1.push_back(bus1.sram_wdata_o);
      if (!in_valid) bad_wr++;
    end
    if (bus1.sram_cs_o && !bus1.sram_wen_o) rd1++;
    if (bus3.sram_cs_o && !bus3.sram_wen_o) rd3++;
    if (bus1.out_valid_o && out_ready) begin
      od1.push_back(bus1.out_data_o);
      ol1.push_back(bus1.out_last_o);
    end
    if (bus3.out_valid_o && out_ready) begin
      od3.push_back(bus3.out_data_o);
      ol3.push_back(bus3.out_last_o);
    end
  end

  // k-th output of a frame whose i-th input was base+i.
  function automatic logic [DW-1:0] exp_data(input int base, input int k);
    logic [AW-1:0] a;
    a = AW'(k);
`ifdef FFT_BITREV_EN
    a = {a[0], a[1], a[2]};
`endif
    return DW'(base + int'(a));
  endfunction

  // Called at posedge+1 with both controllers in FILL; returns in the DRAIN entry cycle
  // (or one cycle later when gap is set).
  task automatic send(input int base, input bit gap, input bit rnd);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd, input string tag);
    int n = 0;
    while (!(bus1.in_ready_o && bus3.in_ready_o) && n < 300) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL %s_idle_timeout got=%0d cycles required<300", tag, n);
    end
  endtask

  task automatic test_reset();
    for (int p = 0; p < 2; p++) begin
      if (p == 0) #2;
      else begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
      end
      checks += 4;
      if ({bus1.in_ready_o, bus1.out_valid_o, bus1.out_last_o, bus1.sram_cs_o,
           bus1.sram_wen_o, bus1.busy_o} !== 6'b100000) begin
        failures++;
        $display("FAIL reset_ctrl1 phase=%0d got=%b required=100000", p,
                 {bus1.in_ready_o, bus1.out_valid_o, bus1.out_last_o, bus1.sram_cs_o,
                  bus1.sram_wen_o, bus1.busy_o});
      end
      if ({bus3.in_ready_o, bus3.out_valid_o, bus3.out_last_o, bus3.sram_cs_o,
           bus3.sram_wen_o, bus3.busy_o} !== 6'b100000) begin
        failures++;
        $display("FAIL reset_ctrl3 phase=%0d got=%b required=100000", p,
                 {bus3.in_ready_o, bus3.out_valid_o, bus3.out_last_o, bus3.sram_cs_o,
                  bus3.sram_wen_o, bus3.busy_o});
      end
      if ({bus1.sram_addr_o, bus1.sram_wdata_o, bus1.out_data_o} !== '0) begin
        failures++;
        $display("FAIL reset_data1 phase=%0d got=%h required=0", p,
                 {bus1.sram_addr_o, bus1.sram_wdata_o, bus1.out_data_o});
      end
      if ({bus3.sram_addr_o, bus3.sram_wdata_o, bus3.out_data_o} !== '0) begin
        failures++;
        $display("FAIL reset_data3 phase=%0d got=%h required=0", p,
                 {bus3.sram_addr_o, bus3.sram_wdata_o, bus3.out_data_o});
      end
    end
  endtask

  // Inputs 0..7 with ready high: outputs 0,4,2,6,1,5,3,7 when bit reversal is built in.
  // in_ready stays low for N reads + Latency + 1 FIFO cycle: 10 (lat 1) and 12 (lat 3).
  task automatic test_fill_drain();
    int ws, o1, o3, lo1, lo3;
    bit d1, d3;
    out_ready = 1'b1;
    @(posedge clk); #1;
    ws = wa1.size(); o1 = od1.size(); o3 = od3.size();
    send(0, 1'b0, 1'b0);
    checks++;
    if (bus1.busy_o !== 1'b1) begin
      failures++;
      $display("FAIL drain_busy got=%b required=1", bus1.busy_o);
    end
    lo1 = 0; lo3 = 0; d1 = 0; d3 = 0;
    for (int n = 0; n < 40 && !(d1 && d3); n++) begin
      if (!d1) begin if (bus1.in_ready_o) d1 = 1; else lo1++; end
      if (!d3) begin if (bus3.in_ready_o) d3 = 1; else lo3++; end
      @(posedge clk); #1;
    end
    checks += 3;
    if (lo1 != 10) begin
      failures++; $display("FAIL ready_low1 got=%0d required=10", lo1);
    end
    if (lo3 != 12) begin
      failures++; $display("FAIL ready_low3 got=%0d required=12", lo3);
    end
    if (wa1.size() - ws != N) begin
      failures++; $display("FAIL write_count got=%0d required=%0d", wa1.size() - ws, N);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({wa1[ws+k], wd1[ws+k]} !== {AW'(k), DW'(k)}) begin
        failures++;
        $display("FAIL write_%0d got=addr %0d data %0d required=addr %0d data %0d",
                 k, wa1[ws+k], wd1[ws+k], k, k);
      end
    end
    checks += 3;
    if (od1.size() - o1 != N) begin
      failures++; $display("FAIL out_count1 got=%0d required=%0d", od1.size() - o1, N);
    end
    if (od3.size() - o3 != N) begin
      failures++; $display("FAIL out_count3 got=%0d required=%0d", od3.size() - o3, N);
    end
    if (bus1.busy_o !== 1'b0) begin
      failures++; $display("FAIL idle_busy got=%b required=0", bus1.busy_o);
    end
    for (int k = 0; k < N; k++) begin
      checks += 2;
      if ({ol1[o1+k], od1[o1+k]} !== {k == N - 1, exp_data(0, k)}) begin
        failures++;
        $display("FAIL fd_out1_%0d got=last %b data %0d required=last %b data %0d", k,
                 ol1[o1+k], od1[o1+k], k == N - 1, exp_data(0, k));
      end
      if ({ol3[o3+k], od3[o3+k]} !== {k == N - 1, exp_data(0, k)}) begin
        failures++;
        $display("FAIL fd_out3_%0d got=last %b data %0d required=last %b data %0d", k,
                 ol3[o3+k], od3[o3+k], k == N - 1, exp_data(0, k));
      end
    end
  endtask

  // Ready low for 10 DRAIN cycles: reads stop at Latency+1 credits (4 for lat 3, 2 for lat 1).
  task automatic test_backpressure();
    int r1, r3, o1, o3;
    out_ready = 1'b0;
    r1 = rd1; r3 = rd3; o1 = od1.size(); o3 = od3.size();
    send(20, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checks += 5;
    if (rd3 - r3 != 4) begin
      failures++; $display("FAIL bp_reads3 got=%0d required=4", rd3 - r3);
    end
    if (rd1 - r1 != 2) begin
      failures++; $display("FAIL bp_reads1 got=%0d required=2", rd1 - r1);
    end
    if (od3.size() != o3) begin
      failures++; $display("FAIL bp_no_pop3 got=%0d required=%0d", od3.size(), o3);
    end
    if ({bus3.out_valid_o, bus3.out_data_o} !== {1'b1, exp_data(20, 0)}) begin
      failures++;
      $display("FAIL bp_head3 got=valid %b data %0d required=valid 1 data %0d",
               bus3.out_valid_o, bus3.out_data_o, exp_data(20, 0));
    end
    if ({bus1.out_valid_o, bus1.out_data_o} !== {1'b1, exp_data(20, 0)}) begin
      failures++;
      $display("FAIL bp_head1 got=valid %b data %0d required=valid 1 data %0d",
               bus1.out_valid_o, bus1.out_data_o, exp_data(20, 0));
    end
    out_ready = 1'b1;
    wait_idle(1'b0, "bp");
    checks += 2;
    if (od3.size() - o3 != N) begin
      failures++; $display("FAIL bp_count3 got=%0d required=%0d", od3.size() - o3, N);
    end
    if (od1.size() - o1 != N) begin
      failures++; $display("FAIL bp_count1 got=%0d required=%0d", od1.size() - o1, N);
    end
    for (int k = 0; k < N; k++) begin
      checks += 2;
      if ({ol3[o3+k], od3[o3+k]} !== {k == N - 1, exp_data(20, k)}) begin
        failures++;
        $display("FAIL bp_out3_%0d got=last %b data %0d required=last %b data %0d", k,
                 ol3[o3+k], od3[o3+k], k == N - 1, exp_data(20, k));
      end
      if ({ol1[o1+k], od1[o1+k]} !== {k == N - 1, exp_data(20, k)}) begin
        failures++;
        $display("FAIL bp_out1_%0d got=last %b data %0d required=last %b data %0d", k,
                 ol1[o1+k], od1[o1+k], k == N - 1, exp_data(20, k));
      end
    end
  endtask

  task automatic test_gapped_input();
    int ws, bw, o1;
    out_ready = 1'b1;
    ws = wa1.size(); bw = bad_wr; o1 = od1.size();
    send(40, 1'b1, 1'b0);
    wait_idle(1'b0, "gap");
    checks += 2;
    if (bad_wr != bw) begin
      failures++; $display("FAIL gap_stray_writes got=%0d required=0", bad_wr - bw);
    end
    if (wa1.size() - ws != N) begin
      failures++; $display("FAIL gap_write_count got=%0d required=%0d", wa1.size() - ws, N);
    end
    for (int k = 0; k < N; k++) begin
      checks += 2;
      if ({wa1[ws+k], wd1[ws+k]} !== {AW'(k), DW'(40 + k)}) begin
        failures++;
        $display("FAIL gap_write_%0d got=addr %0d data %0d required=addr %0d data %0d",
                 k, wa1[ws+k], wd1[ws+k], k, 40 + k);
      end
      if ({ol1[o1+k], od1[o1+k]} !== {k == N - 1, exp_data(40, k)}) begin
        failures++;
        $display("FAIL gap_out_%0d got=last %b data %0d required=last %b data %0d", k,
                 ol1[o1+k], od1[o1+k], k == N - 1, exp_data(40, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int o1, o3, f, k;
    int bases [3];
    bases[0] = 60; bases[1] = 80; bases[2] = 100;
    o1 = od1.size(); o3 = od3.size();
    for (int i = 0; i < 3; i++) begin
      send(bases[i], 1'b0, 1'b1);
      wait_idle(1'b1, "b2b");
    end
    out_ready = 1'b1;
    checks += 2;
    if (od1.size() - o1 != 3 * N) begin
      failures++; $display("FAIL b2b_count1 got=%0d required=%0d", od1.size() - o1, 3 * N);
    end
    if (od3.size() - o3 != 3 * N) begin
      failures++; $display("FAIL b2b_count3 got=%0d required=%0d", od3.size() - o3, 3 * N);
    end
    for (int j = 0; j < 3 * N; j++) begin
      f = j / N; k = j % N;
      checks += 2;
      if ({ol1[o1+j], od1[o1+j]} !== {k == N - 1, exp_data(bases[f], k)}) begin
        failures++;
        $display("FAIL b2b_out1_%0d got=last %b data %0d required=last %b data %0d", j,
                 ol1[o1+j], od1[o1+j], k == N - 1, exp_data(bases[f], k));
      end
      if ({ol3[o3+j], od3[o3+j]} !== {k == N - 1, exp_data(bases[f], k)}) begin
        failures++;
        $display("FAIL b2b_out3_%0d got=last %b data %0d required=last %b data %0d", j,
                 ol3[o3+j], od3[o3+j], k == N - 1, exp_data(bases[f], k));
      end
    end
  endtask

  task automatic test_reset_mid();
    int r1, n, o1, o3;
    out_ready = 1'b1;
    r1 = rd1;
    send(120, 1'b0, 1'b0);
    n = 0;
    while (rd1 - r1 < 3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (rd1 - r1 < 3) begin
      failures++; $display("FAIL mid_reads got=%0d required>=3", rd1 - r1);
    end
    if ({bus1.in_ready_o, bus1.out_valid_o, bus1.out_last_o, bus1.sram_cs_o,
         bus1.sram_wen_o, bus1.busy_o, bus1.out_data_o, bus1.sram_addr_o}
        !== {6'b100000, 12'b0}) begin
      failures++;
      $display("FAIL mid_reset1 got=%b required=100000 and zero data",
               {bus1.in_ready_o, bus1.out_valid_o, bus1.out_last_o, bus1.sram_cs_o,
                bus1.sram_wen_o, bus1.busy_o, bus1.out_data_o, bus1.sram_addr_o});
    end
    if ({bus3.in_ready_o, bus3.out_valid_o, bus3.sram_cs_o, bus3.busy_o} !== 4'b1000) begin
      failures++;
      $display("FAIL mid_reset3 got=%b required=1000",
               {bus3.in_ready_o, bus3.out_valid_o, bus3.sram_cs_o, bus3.busy_o});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    o1 = od1.size(); o3 = od3.size();
    send(140, 1'b0, 1'b0);
    wait_idle(1'b0, "mid");
    checks += 2;
    if (od1.size() - o1 != N) begin
      failures++; $display("FAIL mid_count1 got=%0d required=%0d", od1.size() - o1, N);
    end
    if (od3.size() - o3 != N) begin
      failures++; $display("FAIL mid_count3 got=%0d required=%0d", od3.size() - o3, N);
    end
    for (int k = 0; k < N; k++) begin
      checks += 2;
      if ({ol1[o1+k], od1[o1+k]} !== {k == N - 1, exp_data(140, k)}) begin
        failures++;
        $display("FAIL mid_out1_%0d got=last %b data %0d required=last %b data %0d", k,
                 ol1[o1+k], od1[o1+k], k == N - 1, exp_data(140, k));
      end
      if ({ol3[o3+k], od3[o3+k]} !== {k == N - 1, exp_data(140, k)}) begin
        failures++;
        $display("FAIL mid_out3_%0d got=last %b data %0d required=last %b data %0d", k,
                 ol3[o3+k], od3[o3+k], k == N - 1, exp_data(140, k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_gapped_input();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
